// File: rtl/aes_gf_pkg.sv
// Shared constants and types for the AES GF(2^8) arithmetic blocks.
package aes_gf_pkg;

    // Low byte of the AES reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
    localparam logic [7:0] GF_POLY = 8'h1B;

    // Square-and-multiply rounds needed for x^254 = x^(2+4+...+128).
    localparam int unsigned INV_ITERS = 7;

    // Counter value on the final multiply round.
    localparam logic [2:0] INV_LAST_ITER = 3'(INV_ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } gf_inv_state_t;

endpackage : aes_gf_pkg

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier over the AES polynomial.
// Shared by the inverse, forward S-box and MixColumns paths.
module gf256_mul
    import aes_gf_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    // Shift-and-add: accumulate a*x^i for each set bit of b, reducing on carry-out.
    always_comb begin
        logic [7:0] a_sh;
        logic [7:0] prod;
        logic       carry;
        a_sh  = a;
        prod  = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ a_sh;
            end
            carry = a_sh[7];
            a_sh  = {a_sh[6:0], 1'b0};
            if (carry) begin
                a_sh = a_sh ^ GF_POLY;
            end
        end
        p = prod;
    end

endmodule : gf256_mul

// File: rtl/gf256_inv_seq.sv
// Iterative GF(2^8) inverter: x^-1 = x^254 using one time-shared multiplier.
// Accepts a byte in IDLE, runs 7 square/multiply pairs, then holds the result in DONE.
module gf256_inv_seq
    import aes_gf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    gf_inv_state_t state_q, state_d;
    logic [7:0]    sq_q, sq_d;
    logic [7:0]    acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [7:0]    mul_a;
    logic [7:0]    mul_out;

    // Operand select: squaring in SQ, accumulate-multiply in MUL.
    always_comb begin
        mul_a = (state_q == MUL) ? acc_q : sq_q;
    end

    gf256_mul u_mul (
        .a (mul_a),
        .b (sq_q),
        .p (mul_out)
    );

    // Next-state and datapath update for the square-and-multiply sequence.
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sq_d    = in_data;
                    acc_d   = 8'h01;
                    cnt_d   = '0;
                    state_d = SQ;
                end
            end
            SQ: begin
                sq_d    = mul_out;
                state_d = MUL;
            end
            MUL: begin
                acc_d = mul_out;
                if (cnt_q == INV_LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = SQ;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are decoded from the next state so the registered
        // copies always equal a decode of the current state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and handshake registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sq_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_q        <= sq_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;

endmodule : gf256_inv_seq
